pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the WISC pipeline. It sits beside the
//  IF..WB chain and drives the IF hazard, IFID hazard and IDEX bubble controls, plus
//  the EX operand-forward selects. It keeps a shadow scoreboard of {valid,rd,wr,load}
//  for the DEPTH stages past ID. It resolves RAW hazards, load-use stalls, EX-resolved
//  redirects (branch/call/ret) and memory freezes.
// PARAMETERS
//  REG_AW      4  register index width (2**REG_AW architectural registers)
//  DEPTH       3  tracked stages past ID (1=EX, 2=MEM, 3=WB); legal range 1..7
//  LOAD_LAT    1  stages a load's data is unavailable for forwarding; must be < DEPTH
//  FLUSH_CYC   1  cycles of squash after a redirect; legal range 1..7
//  R0_ZERO     1  1: register 0 is hardwired zero, so it never matches a hazard
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         synchronous, active-high reset
//  id_valid     in   1         ID holds a real instruction
//  id_rs        in   REG_AW    ID source register 1
//  id_rt        in   REG_AW    ID source register 2
//  id_rs_use    in   1         rs is read by the ID instruction
//  id_rt_use    in   1         rt is read by the ID instruction
//  id_rd        in   REG_AW    ID destination register
//  id_reg_wr    in   1         ID instruction writes rd
//  id_load      in   1         ID instruction is a load
//  ex_redirect  in   1         EX resolved a taken branch, call or ret this cycle
//  mem_busy     in   1         data memory not ready; freezes the whole pipe
//  stall_if     out  1         hold PC (wired to the IF hazard input)
//  stall_id     out  1         hold the IFID register
//  freeze       out  1         hold every pipe register (= mem_busy)
//  flush_ifid   out  1         replace IFID contents with NOP
//  bubble_ex    out  1         load NOP into IDEX instead of the ID instruction
//  fwd_a_sel    out  FW        EX operand A source, FW=$clog2(DEPTH+1); 0=regfile, k=stage k
//  fwd_b_sel    out  FW        EX operand B source, same encoding
// BEHAVIOUR
//  Reset: scoreboard all invalid; state=RUN; all outputs 0. Outputs are 0 in the rst cycle.
//  Match(k,r): sb[k].valid & sb[k].wr & sb[k].rd==r & !(R0_ZERO & r==0).
//  Hazard is combinational in the ID cycle.
//   lu_stall = id_valid & exists k<LOAD_LAT with sb[k].load and
//              (Match(k,rs)&id_rs_use | Match(k,rt)&id_rt_use).
//  Priority per cycle: rst > mem_busy > ex_redirect/FLUSH > lu_stall > advance.
//  mem_busy: freeze=1. Scoreboard, FSM and fwd_*_sel hold. Every other output is 0.
//  FSM RUN: ex_redirect -> flush_ifid=1, bubble_ex=1; load cnt=FLUSH_CYC-1;
//   go to FLUSH if FLUSH_CYC>1.
//  FSM FLUSH: flush_ifid=1, bubble_ex=1, cnt-- ; go to RUN when cnt==0.
//   A new ex_redirect in FLUSH reloads cnt. No stall is raised while flushing.
//  lu_stall (RUN, no redirect): stall_if=stall_id=1, bubble_ex=1; the ID instruction is
//   retried next cycle. Latency is exactly LOAD_LAT stall cycles for an adjacent use.
//  Advance (no freeze) shifts the scoreboard: sb[k+1]<=sb[k]. sb[0]<=ID fields if
//   id_valid & !bubble_ex, else invalid. sb[DEPTH-1] retires.
//  fwd_*_sel is registered on advance and is valid while the instruction sits in EX.
//   Value = smallest k+1 with Match(k,r) (youngest wins), else 0. It is 0 when bubble_ex.
//   The scoreboard is read before it shifts.
//  Simultaneous ex_redirect & lu_stall: the redirect wins and the stall is dropped
//   (the ID instruction is squashed).
//  rst mid-flush or mid-stall: return to RUN with an empty scoreboard next cycle.
// STRUCTURE
//  wisc_pkg: sb_entry_t {valid,wr,load,rd}, hz_state_e {RUN,FLUSH},
//   fwd-select localparams FWD_RF=0.
//  Sub-module hazard_scoreboard: DEPTH-entry shift register with hold/insert-bubble and
//   per-source match vectors.
//  The top holds the FSM, flush counter, priority logic and fwd-select registers.
// TESTING
//  add r1; add r2,r1 back-to-back -> no stall; fwd_a_sel=1 in EX cycle of 2nd.
//  lw r3; add r4,r3 -> 1 cycle stall_if/stall_id/bubble_ex; then fwd_a_sel=2.
//  ex_redirect pulse, FLUSH_CYC=2 -> flush_ifid & bubble_ex high 2 cycles; RUN after.
//  Same cycle ex_redirect & load-use -> flush only, stall_if=0.
//  mem_busy 3 cycles amid load-use -> freeze=1; fwd sel stable; stall resumes after.
//  writer rd=r0 (R0_ZERO=1) -> no stall/forward; rst during FLUSH -> all outputs 0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared types for the WISC hazard controller: scoreboard entry, FSM states and
// the register-match helper used by the scoreboard.
package wisc_pkg;

  localparam int unsigned REG_AW_MAX = 8;
  localparam int unsigned FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  load;
    logic [REG_AW_MAX-1:0] rd;
  } sb_entry_t;

  typedef enum logic {
    RUN,
    FLUSH
  } hz_state_e;

  // Register 0 never creates a dependency when it is hardwired to zero.
  function automatic logic reg_match(input sb_entry_t e, input logic [REG_AW_MAX-1:0] r,
                                     input bit r0_zero);
    return e.valid & e.wr & (e.rd == r) & ~(r0_zero & (r == '0));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of {valid,wr,load,rd} for the DEPTH stages past ID, with per-source
// match vectors; entry 0 is the instruction currently in EX.
module hazard_scoreboard
  import wisc_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned DEPTH   = 3,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  sb_entry_t         i_ins,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  output logic [DEPTH-1:0]  o_match_rs,
  output logic [DEPTH-1:0]  o_match_rt,
  output logic [DEPTH-1:0]  o_load
);

  sb_entry_t             r_sb [DEPTH];
  logic [REG_AW_MAX-1:0] w_rs_ext;
  logic [REG_AW_MAX-1:0] w_rt_ext;

  assign w_rs_ext = REG_AW_MAX'(i_rs);
  assign w_rt_ext = REG_AW_MAX'(i_rt);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < int'(DEPTH); k++) r_sb[k] <= '0;
    end else if (!i_hold) begin
      for (int k = 1; k < int'(DEPTH); k++) r_sb[k] <= r_sb[k-1];
      r_sb[0] <= i_ins;
    end
  end

  always_comb begin
    o_match_rs = '0;
    o_match_rt = '0;
    o_load     = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      o_match_rs[k] = reg_match(r_sb[k], w_rs_ext, R0_ZERO);
      o_match_rt[k] = reg_match(r_sb[k], w_rt_ext, R0_ZERO);
      o_load[k]     = r_sb[k].load;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// WISC hazard/forwarding controller: load-use stalls, redirect flushes, memory
// freezes and registered EX operand-forward selects.
module pipe_hazard_ctrl
  import wisc_pkg::*;
#(
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 1,
  parameter bit          R0_ZERO   = 1'b1,
  localparam int unsigned FW       = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_rs_use,
  input  logic              i_id_rt_use,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_wr,
  input  logic              i_id_load,
  input  logic              i_ex_redirect,
  input  logic              i_mem_busy,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_freeze,
  output logic              o_flush_ifid,
  output logic              o_bubble_ex,
  output logic [FW-1:0]     o_fwd_a_sel,
  output logic [FW-1:0]     o_fwd_b_sel
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYC - 1);

  hz_state_e        r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [FW-1:0]    r_fwd_a, r_fwd_b;
  logic [FW-1:0]    w_fwd_a, w_fwd_b;
  logic [DEPTH-1:0] w_match_rs, w_match_rt, w_load;
  logic             w_lu_stall, w_advance, w_bubble;
  sb_entry_t        w_ins;

  always_comb begin
    w_ins       = '0;
    w_ins.valid = i_id_valid & ~w_bubble;
    w_ins.wr    = i_id_reg_wr;
    w_ins.load  = i_id_load;
    w_ins.rd    = REG_AW_MAX'(i_id_rd);
  end

  hazard_scoreboard #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_hold     (~w_advance),
    .i_ins      (w_ins),
    .i_rs       (i_id_rs),
    .i_rt       (i_id_rt),
    .o_match_rs (w_match_rs),
    .o_match_rt (w_match_rt),
    .o_load     (w_load)
  );

  // Only the youngest LOAD_LAT stages still lack load data.
  always_comb begin
    w_lu_stall = 1'b0;
    for (int k = 0; k < int'(LOAD_LAT); k++) begin
      if (w_load[k] & ((w_match_rs[k] & i_id_rs_use) | (w_match_rt[k] & i_id_rt_use))) begin
        w_lu_stall = 1'b1;
      end
    end
    w_lu_stall = w_lu_stall & i_id_valid;
  end

  // Descending scan so the youngest matching stage wins.
  always_comb begin
    w_fwd_a = FW'(FWD_RF);
    w_fwd_b = FW'(FWD_RF);
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (w_match_rs[k]) w_fwd_a = FW'(k + 1);
      if (w_match_rt[k]) w_fwd_b = FW'(k + 1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_advance    = 1'b0;
    w_bubble     = 1'b0;
    o_stall_if   = 1'b0;
    o_stall_id   = 1'b0;
    o_freeze     = 1'b0;
    o_flush_ifid = 1'b0;
    if (i_rst) begin
      w_state_nxt = RUN;
    end else if (i_mem_busy) begin
      o_freeze = 1'b1;
    end else begin
      w_advance = 1'b1;
      unique case (r_state)
        RUN: begin
          if (i_ex_redirect) begin
            o_flush_ifid = 1'b1;
            w_bubble     = 1'b1;
            w_cnt_nxt    = CNT_LOAD;
            w_state_nxt  = (FLUSH_CYC > 1) ? FLUSH : RUN;
          end else if (w_lu_stall) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            w_bubble   = 1'b1;
          end
        end
        FLUSH: begin
          o_flush_ifid = 1'b1;
          w_bubble     = 1'b1;
          if (i_ex_redirect) begin
            w_cnt_nxt = CNT_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (w_cnt_nxt == 3'd0) w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign o_bubble_ex = w_bubble;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_advance) begin
        r_fwd_a <= w_bubble ? FW'(FWD_RF) : w_fwd_a;
        r_fwd_b <= w_bubble ? FW'(FWD_RF) : w_fwd_b;
      end
    end
  end

  assign o_fwd_a_sel = i_rst ? '0 : r_fwd_a;
  assign o_fwd_b_sel = i_rst ? '0 : r_fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DEPTH=3, LOAD_LAT=1, FLUSH_CYC=2, R0_ZERO=1).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_use, id_rt_use, id_reg_wr, id_load;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       ex_redirect, mem_busy;
  logic       stall_if, stall_id, freeze, flush_ifid, bubble_ex;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .REG_AW    (4),
    .DEPTH     (3),
    .LOAD_LAT  (1),
    .FLUSH_CYC (2),
    .R0_ZERO   (1'b1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_valid    (id_valid),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_rs_use   (id_rs_use),
    .i_id_rt_use   (id_rt_use),
    .i_id_rd       (id_rd),
    .i_id_reg_wr   (id_reg_wr),
    .i_id_load     (id_load),
    .i_ex_redirect (ex_redirect),
    .i_mem_busy    (mem_busy),
    .o_stall_if    (stall_if),
    .o_stall_id    (stall_id),
    .o_freeze      (freeze),
    .o_flush_ifid  (flush_ifid),
    .o_bubble_ex   (bubble_ex),
    .o_fwd_a_sel   (fwd_a_sel),
    .o_fwd_b_sel   (fwd_b_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic id(input logic v, input int rs, input int rt, input logic rsu,
                    input logic rtu, input int rd, input logic wr, input logic ld);
    id_valid  = v;
    id_rs     = 4'(rs);
    id_rt     = 4'(rt);
    id_rs_use = rsu;
    id_rt_use = rtu;
    id_rd     = 4'(rd);
    id_reg_wr = wr;
    id_load   = ld;
  endtask

  task automatic nop();
    id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    ex_redirect = 1'b1;
    mem_busy = 1'b1;
    id(1'b1, 1, 1, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    #2;
    chk("rst_freeze", freeze, 0);
    chk("rst_flush", flush_ifid, 0);
    chk("rst_bubble", bubble_ex, 0);
    chk("rst_stall", stall_if, 0);
    tick();
    tick();
    rst = 1'b0;
    ex_redirect = 1'b0;
    mem_busy = 1'b0;

    // add r1 ; add r2,r1
    id(1'b1, 0, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    #1 chk("c1_fwd_a_reset", fwd_a_sel, 0);
    tick();
    id(1'b1, 1, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    #1 chk("alu_dep_no_stall", stall_if, 0);
    chk("alu_dep_no_bubble", bubble_ex, 0);
    tick();
    nop();
    #1 chk("alu_fwd_a", fwd_a_sel, 1);
    chk("alu_fwd_b", fwd_b_sel, 0);
    tick();

    // lw r3 ; add r4,r3,r3
    id(1'b1, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1);
    #1 chk("nop_fwd_a", fwd_a_sel, 0);
    tick();
    id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    #1 chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    chk("lu_bubble", bubble_ex, 1);
    chk("lu_no_flush", flush_ifid, 0);
    tick();
    #1 chk("lu_retry_no_stall", stall_if, 0);
    chk("lu_retry_no_bubble", bubble_ex, 0);
    chk("lu_bubble_fwd", fwd_a_sel, 0);
    tick();
    nop();
    #1 chk("lu_fwd_a", fwd_a_sel, 2);
    chk("lu_fwd_b", fwd_b_sel, 2);
    tick();

    // Redirect with two flush cycles
    ex_redirect = 1'b1;
    #1 chk("redir_flush0", flush_ifid, 1);
    chk("redir_bubble0", bubble_ex, 1);
    tick();
    ex_redirect = 1'b0;
    #1 chk("redir_flush1", flush_ifid, 1);
    chk("redir_bubble1", bubble_ex, 1);
    tick();
    #1 chk("redir_done_flush", flush_ifid, 0);
    chk("redir_done_bubble", bubble_ex, 0);
    tick();

    // Redirect and load-use together
    id(1'b1, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
    tick();
    id(1'b1, 5, 0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1 chk("both_flush", flush_ifid, 1);
    chk("both_bubble", bubble_ex, 1);
    chk("both_no_stall_if", stall_if, 0);
    chk("both_no_stall_id", stall_id, 0);
    tick();
    ex_redirect = 1'b0;
    nop();
    #1 chk("both_flush1", flush_ifid, 1);
    tick();

    // lw r7 reads r5 from stage 3, then mem_busy over a load-use
    id(1'b1, 5, 0, 1'b1, 1'b0, 7, 1'b1, 1'b1);
    #1 chk("far_dep_no_stall", stall_if, 0);
    tick();
    id(1'b1, 7, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("busy_freeze", freeze, 1);
      chk("busy_no_stall", stall_if, 0);
      chk("busy_no_bubble", bubble_ex, 0);
      chk("busy_fwd_hold", fwd_a_sel, 3);
      tick();
    end
    mem_busy = 1'b0;
    #1 chk("busy_end_freeze", freeze, 0);
    chk("busy_resume_stall", stall_if, 1);
    chk("busy_resume_bubble", bubble_ex, 1);
    tick();
    #1 chk("busy_retry_no_stall", stall_if, 0);
    tick();
    nop();
    #1 chk("busy_lu_fwd", fwd_a_sel, 2);
    tick();

    // Writer to r0 never creates a hazard
    id(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    tick();
    id(1'b1, 0, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0);
    #1 chk("r0_no_stall", stall_if, 0);
    tick();
    nop();
    #1 chk("r0_no_fwd_a", fwd_a_sel, 0);
    chk("r0_no_fwd_b", fwd_b_sel, 0);
    tick();

    // Reset during FLUSH
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    rst = 1'b1;
    #1 chk("rst_flush_mid", flush_ifid, 0);
    chk("rst_bubble_mid", bubble_ex, 0);
    tick();
    rst = 1'b0;
    #1 chk("post_rst_flush", flush_ifid, 0);
    chk("post_rst_bubble", bubble_ex, 0);
    tick();

    // Reset clears a pending load-use
    id(1'b1, 0, 0, 1'b0, 1'b0, 9, 1'b1, 1'b1);
    tick();
    id(1'b1, 9, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
    #1 chk("pre_rst_lu", stall_if, 1);
    rst = 1'b1;
    #1 chk("rst_lu_stall", stall_if, 0);
    tick();
    rst = 1'b0;
    #1 chk("post_rst_lu_stall", stall_if, 0);
    chk("post_rst_fwd", fwd_a_sel, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
